// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache: controller states and
// the byte-address field positions used to slice tag, index and word select.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL0 = 2'd1,
    FILL1 = 2'd2,
    WR    = 2'd3
  } state_e;

  localparam int TAG_LSB  = 7;
  localparam int IDX_LSB  = 3;
  localparam int WSEL_BIT = 2;

endpackage

// File: rtl/data_cache_ctrl_if.sv
// Memory-side bus of the data cache: a request held until a one-cycle ack.
// The cache controller is the master, main memory is the slave.
interface data_cache_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wd,
    input  mem_rd, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wd,
    output mem_rd, mem_ack
  );

endinterface

// File: rtl/dcache_line_array.sv
// Tag/valid/data storage for the direct-mapped cache: combinational read,
// one write port that either fills a whole line or updates a single word.
module dcache_line_array #(
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              line_we_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic [DATA_W-1:0] wword0_i,
  input  logic [DATA_W-1:0] wword1_i,
  input  logic              word_we_i,
  input  logic              wsel_i,
  input  logic [DATA_W-1:0] wword_i,
  output logic              valid_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] word0_o,
  output logic [DATA_W-1:0] word1_o
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q   [LINES];
  logic [DATA_W-1:0] word0_q [LINES];
  logic [DATA_W-1:0] word1_q [LINES];

  // Only the valid bits are reset; stale tags/data are harmless once invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we_i) begin
      tag_q[idx_i]   <= wtag_i;
      word0_q[idx_i] <= wword0_i;
      word1_q[idx_i] <= wword1_i;
    end else if (word_we_i) begin
      if (wsel_i) word1_q[idx_i] <= wword_i;
      else        word0_q[idx_i] <= wword_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign word0_o = word0_q[idx_i];
  assign word1_o = word1_q[idx_i];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-through data cache controller: zero-latency load hits,
// two-word refill on a load miss, single-word write-through on every store.
module data_cache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  input  logic              flush,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              cpu_stall,
  output logic              read_hit,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  data_cache_ctrl_if.master mem
);

  localparam int TAG_W = ADDR_W - TAG_LSB;

  state_e            state_q, state_d;
  logic              retry_q, retry_d;
  logic [DATA_W-1:0] word0_q, word0_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  hit_q, hit_d;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic              wsel;
  logic              hit;
  logic              line_we;
  logic              word_we;
  logic              arr_valid;
  logic [TAG_W-1:0]  arr_tag;
  logic [DATA_W-1:0] arr_word0;
  logic [DATA_W-1:0] arr_word1;
  logic              unused_addr_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign tag              = cpu_addr[ADDR_W-1:TAG_LSB];
  assign idx              = cpu_addr[IDX_LSB +: IDX_W];
  assign wsel             = cpu_addr[WSEL_BIT];
  assign unused_addr_bits = ^cpu_addr[WSEL_BIT-1:0];

  dcache_line_array #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_lines (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush && (state_q == IDLE)),
    .idx_i     (idx),
    .line_we_i (line_we),
    .wtag_i    (tag),
    .wword0_i  (word0_q),
    .wword1_i  (mem.mem_rd),
    .word_we_i (word_we),
    .wsel_i    (wsel),
    .wword_i   (cpu_wd),
    .valid_o   (arr_valid),
    .tag_o     (arr_tag),
    .word0_o   (arr_word0),
    .word1_o   (arr_word1)
  );

  assign hit    = arr_valid && (arr_tag == tag);
  assign cpu_rd = wsel ? arr_word1 : arr_word0;

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    word0_d      = word0_q;
    acc_d        = acc_q;
    hit_d        = hit_q;
    cpu_stall    = 1'b0;
    read_hit     = 1'b0;
    line_we      = 1'b0;
    word_we      = 1'b0;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_addr = {cpu_addr[ADDR_W-1:WSEL_BIT+1], 1'b0, 2'b00};
    mem.mem_wd   = cpu_wd;
    unique case (state_q)
      IDLE: begin
        // A flush wins over any request; the request is re-looked-up next cycle.
        if (flush) begin
          cpu_stall = cpu_re | cpu_we;
        end else if (cpu_we) begin
          cpu_stall = 1'b1;
          word_we   = hit;
          state_d   = WR;
        end else if (cpu_re) begin
          if (hit) begin
            acc_d   = sat_inc(acc_q);
            retry_d = 1'b0;
            if (!retry_q) begin
              read_hit = 1'b1;
              hit_d    = sat_inc(hit_q);
            end
          end else begin
            cpu_stall = 1'b1;
            state_d   = FILL0;
          end
        end
      end
      FILL0: begin
        cpu_stall   = 1'b1;
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          word0_d = mem.mem_rd;
          state_d = FILL1;
        end
      end
      FILL1: begin
        cpu_stall    = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_addr = {cpu_addr[ADDR_W-1:WSEL_BIT+1], 1'b1, 2'b00};
        if (mem.mem_ack) begin
          line_we = 1'b1;
          retry_d = 1'b1;
          state_d = IDLE;
        end
      end
      WR: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.mem_addr = {cpu_addr[ADDR_W-1:WSEL_BIT], 2'b00};
        cpu_stall    = !mem.mem_ack;
        if (mem.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      retry_q <= 1'b0;
      acc_q   <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      acc_q   <= acc_d;
      hit_q   <= hit_d;
    end
  end

  always_ff @(posedge clk) begin
    word0_q <= word0_d;
  end

  assign acc_cnt = acc_q;
  assign hit_cnt = hit_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: directed scenarios plus random
// loads/stores/flushes checked against a tag/valid model over a memory array.
module tb_data_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_re, cpu_we, flush;
  logic [10:0] cpu_addr;
  logic [31:0] cpu_wd, cpu_rd;
  logic        cpu_stall, read_hit;
  logic [15:0] acc_cnt, hit_cnt;

  always #5 clk = ~clk;

  data_cache_ctrl_if #(.ADDR_W(11), .DATA_W(32)) mif ();

  data_cache_ctrl #(
    .ADDR_W(11), .IDX_W(4), .DATA_W(32), .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wd    (cpu_wd),
    .flush     (flush),
    .cpu_rd    (cpu_rd),
    .cpu_stall (cpu_stall),
    .read_hit  (read_hit),
    .acc_cnt   (acc_cnt),
    .hit_cnt   (hit_cnt),
    .mem       (mif.master)
  );

  logic [31:0] mem_m [512];
  bit          vld_m [16];
  int          tag_m [16];
  int          acc_m, hit_m;
  int          n_chk, n_fail;
  logic [10:0] ack_addr [$];
  bit          ack_we   [$];
  logic [31:0] ack_wd   [$];

  function automatic int sat(input int v, input int inc);
    return (v + inc > 65535) ? 65535 : v + inc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one CPU request from a negedge until the cycle it completes,
  // acting as main memory with a random 0..2 cycle wait per request.
  task automatic access(input bit re, input bit we, input logic [10:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output bit rh, output int stalls, output int nreq,
                        output int lat_sum);
    bit done;
    int lat;
    done = 0; lat = -1; rd = '0; rh = 0; stalls = 0; nreq = 0; lat_sum = 0;
    ack_addr.delete(); ack_we.delete(); ack_wd.delete();
    cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wd = wd;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      mif.mem_ack = 1'b0;
      if (mif.mem_req) begin
        if (lat < 0) begin
          lat = $urandom_range(0, 2);
          lat_sum += lat;
        end
        if (lat == 0) begin
          mif.mem_ack = 1'b1;
          nreq++;
          ack_addr.push_back(mif.mem_addr);
          ack_we.push_back(mif.mem_we);
          ack_wd.push_back(mif.mem_wd);
          if (mif.mem_we) mem_m[mif.mem_addr[10:2]] = mif.mem_wd;
          else            mif.mem_rd = mem_m[mif.mem_addr[10:2]];
          lat = -1;
        end else begin
          lat--;
        end
      end
      #1;
      if (!cpu_stall) begin
        done = 1;
        rd   = cpu_rd;
        rh   = read_hit;
      end else begin
        stalls++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    cpu_re = 1'b0; cpu_we = 1'b0; mif.mem_ack = 1'b0;
    chk("complete", done, 1);
  endtask

  task automatic ref_load(input logic [10:0] a);
    logic [31:0] rd, exp_rd;
    bit rh, hit;
    int st, nr, ls, idx, tg;
    idx    = int'(a[6:3]);
    tg     = int'(a[10:7]);
    hit    = vld_m[idx] && (tag_m[idx] == tg);
    exp_rd = mem_m[a[10:2]];
    access(1'b1, 1'b0, a, 32'h0, rd, rh, st, nr, ls);
    chk("load_data", rd, exp_rd);
    if (hit) begin
      chk("hit_nreq", nr, 0);
      chk("hit_stall", st, 0);
      chk("hit_pulse", rh, 1);
      hit_m = sat(hit_m, 1);
    end else begin
      chk("miss_nreq", nr, 2);
      chk("miss_stall", st, 3 + ls);
      chk("miss_pulse", rh, 0);
      if (ack_addr.size() == 2) begin
        chk("fill_addr0", ack_addr[0], {a[10:3], 3'b000});
        chk("fill_addr1", ack_addr[1], {a[10:3], 3'b100});
        chk("fill_we", {ack_we[0], ack_we[1]}, 0);
      end
      vld_m[idx] = 1;
      tag_m[idx] = tg;
    end
    acc_m = sat(acc_m, 1);
    chk("acc_cnt", acc_cnt, acc_m);
    chk("hit_cnt", hit_cnt, hit_m);
  endtask

  task automatic ref_store(input logic [10:0] a, input logic [31:0] wd, input bit also_re);
    logic [31:0] rd;
    bit rh;
    int st, nr, ls;
    access(also_re, 1'b1, a, wd, rd, rh, st, nr, ls);
    chk("wr_nreq", nr, 1);
    chk("wr_stall", st, 1 + ls);
    chk("wr_pulse", rh, 0);
    if (ack_addr.size() == 1) begin
      chk("wr_addr", ack_addr[0], {a[10:2], 2'b00});
      chk("wr_we", ack_we[0], 1);
      chk("wr_data", ack_wd[0], wd);
    end
    chk("wr_acc_cnt", acc_cnt, acc_m);
    chk("wr_hit_cnt", hit_cnt, hit_m);
  endtask

  task automatic flush_op(input bit with_req, input logic [10:0] a);
    flush = 1'b1; cpu_re = with_req; cpu_addr = a;
    #1;
    chk("flush_stall", cpu_stall, with_req);
    chk("flush_no_req", mif.mem_req, 0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; cpu_re = 1'b0;
    for (int i = 0; i < 16; i++) vld_m[i] = 0;
    if (with_req) ref_load(a);
  endtask

  task automatic idle_ack();
    mif.mem_ack = 1'b1; mif.mem_rd = $urandom;
    #1;
    chk("idle_ack_req", mif.mem_req, 0);
    chk("idle_ack_stall", cpu_stall, 0);
    @(posedge clk);
    @(negedge clk);
    mif.mem_ack = 1'b0;
  endtask

  initial begin
    bit reached;
    n_chk = 0; n_fail = 0; acc_m = 0; hit_m = 0;
    rst_n = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; flush = 1'b0;
    cpu_addr = '0; cpu_wd = '0; mif.mem_ack = 1'b0; mif.mem_rd = '0;
    for (int i = 0; i < 512; i++) mem_m[i] = $urandom;
    for (int i = 0; i < 16; i++) begin vld_m[i] = 0; tag_m[i] = 0; end
    mem_m[4] = 32'h1111_1111;
    mem_m[5] = 32'h2222_2222;

    @(negedge clk);
    chk("rst_mem_req", mif.mem_req, 0);
    chk("rst_mem_we", mif.mem_we, 0);
    chk("rst_read_hit", read_hit, 0);
    chk("rst_acc_cnt", acc_cnt, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    ref_load(11'h010);
    ref_load(11'h014);
    ref_store(11'h014, 32'hDEAD_BEEF, 1'b0);
    ref_load(11'h014);
    chk("store_visible", mem_m[5], 32'hDEAD_BEEF);
    ref_load(11'h410);
    ref_load(11'h010);
    idle_ack();
    ref_load(11'h014);

    // Reset while the second refill word is outstanding.
    cpu_re = 1'b1; cpu_addr = 11'h410; reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      #1;
      mif.mem_ack = 1'b0;
      if (mif.mem_req && mif.mem_addr == 11'h414) begin
        reached = 1;
      end else begin
        if (mif.mem_req) begin
          mif.mem_ack = 1'b1;
          mif.mem_rd  = mem_m[mif.mem_addr[10:2]];
        end
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("reach_fill1", reached, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", mif.mem_req, 0);
    chk("async_rst_acc", acc_cnt, 0);
    chk("async_rst_hit", hit_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; cpu_re = 1'b0;
    acc_m = 0; hit_m = 0;
    for (int i = 0; i < 16; i++) vld_m[i] = 0;
    ref_load(11'h010);

    ref_load(11'h014);
    flush_op(1'b1, 11'h010);
    flush_op(1'b0, 11'h000);
    ref_load(11'h014);

    for (int n = 0; n < 300; n++) begin
      logic [10:0] a;
      int op;
      a  = {2'($urandom_range(0, 3)) == 2'd3 ? 4'h8 : 4'($urandom_range(0, 2)),
            4'($urandom_range(0, 3)), 1'($urandom), 2'($urandom)};
      op = $urandom_range(0, 99);
      if (op < 60)      ref_load(a);
      else if (op < 90) ref_store(a, $urandom, 1'($urandom));
      else if (op < 95) flush_op(1'($urandom), a);
      else              idle_ack();
    end

    ref_load(11'h010);
    ref_load(11'h010);
    cpu_re = 1'b1; cpu_addr = 11'h010;
    #1;
    chk("sat_hit_stall", cpu_stall, 0);
    repeat (65600) @(posedge clk);
    @(negedge clk);
    cpu_re = 1'b0;
    acc_m = sat(acc_m, 65600);
    hit_m = sat(hit_m, 65600);
    chk("sat_acc_cnt", acc_cnt, acc_m);
    chk("sat_hit_cnt", hit_cnt, hit_m);
    ref_load(11'h014);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
